// File: rtl/elevator_step_sequencer.sv
// ----------------------------------------------------------------------------
// elevator_step_sequencer
// Motion sequencer for one elevator car's stepper drive. Accepts move commands
// (direction + step count) over valid/ready, emits one-cycle step strobes at a
// fixed rate to the phase generator and tracks absolute car position with hard
// travel limits at 0 and POS_MAX.
// ----------------------------------------------------------------------------

module elevator_step_sequencer #(
   parameter int CNT_W    = 16,
   parameter int POS_W    = 16,
   parameter int POS_MAX  = 4000,
   parameter int STEP_DIV = 100000,
   parameter int HOLD_CYC = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             abort,
   output logic             step_pulse,
   output logic             motor_dir,
   output logic             motor_hold,
   output logic             busy,
   output logic             done,
   output logic             limit_err,
   output logic [POS_W-1:0] position
);

   // Divider needs STEP_DIV distinct values, hold counter HOLD_CYC values.
   localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 32'd1);
   localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(POS_MAX);
   localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [POS_W-1:0]  POS_ZERO  = {POS_W{1'b0}};
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1'b1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
   localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_s;

   logic [DIV_W-1:0]   div_r;
   logic [DIV_W-1:0]   div_s;
   logic [HOLD_W-1:0]  hold_r;
   logic [HOLD_W-1:0]  hold_s;
   logic [CNT_W-1:0]   remaining_r;
   logic [CNT_W-1:0]   remaining_s;
   logic [POS_W-1:0]   position_r;
   logic [POS_W-1:0]   position_s;
   logic               motor_dir_r;
   logic               motor_dir_s;
   logic               step_pulse_r;
   logic               step_pulse_s;
   logic               done_r;
   logic               done_s;
   logic               limit_err_r;
   logic               limit_err_s;
   logic               motor_hold_r;

   logic               handshake_s;
   logic               wrap_s;
   logic               at_limit_s;

   // Handshake, divider wrap and travel-limit qualifiers.
   always_comb begin
      handshake_s = cmd_valid & (state_r == ST_IDLE);
      wrap_s      = (div_r == DIV_LAST);
      if (motor_dir_r) begin
         at_limit_s = (position_r == POS_TOP);
      end else begin
         at_limit_s = (position_r == POS_ZERO);
      end
   end

   // Next-state and next-datapath logic for the IDLE -> RUN -> STOP sequence.
   always_comb begin
      state_s      = state_r;
      div_s        = div_r;
      hold_s       = hold_r;
      remaining_s  = remaining_r;
      position_s   = position_r;
      motor_dir_s  = motor_dir_r;
      step_pulse_s = 1'b0;
      done_s       = 1'b0;
      limit_err_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // abort has no effect here; only a handshake starts anything.
            if (handshake_s) begin
               motor_dir_s = cmd_dir;
               remaining_s = cmd_steps;
               div_s       = DIV_ZERO;
               hold_s      = HOLD_ZERO;
               if (cmd_steps == CNT_ZERO) begin
                  // Zero-length move completes without ever energising.
                  done_s = 1'b1;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (abort) begin
               // Abort beats a coincident wrap tick: no step this cycle.
               state_s = ST_STOP;
               div_s   = DIV_ZERO;
               hold_s  = HOLD_ZERO;
            end else if (wrap_s) begin
               div_s = DIV_ZERO;
               if (at_limit_s) begin
                  // Step would leave the shaft; drop remaining steps.
                  limit_err_s = 1'b1;
                  state_s     = ST_STOP;
                  hold_s      = HOLD_ZERO;
               end else begin
                  step_pulse_s = 1'b1;
                  remaining_s  = remaining_r - CNT_ONE;
                  if (motor_dir_r) begin
                     position_s = position_r + POS_ONE;
                  end else begin
                     position_s = position_r - POS_ONE;
                  end
                  if (remaining_r == CNT_ONE) begin
                     state_s = ST_STOP;
                     hold_s  = HOLD_ZERO;
                  end else begin
                     state_s = ST_RUN;
                  end
               end
            end else begin
               div_s = div_r + DIV_ONE;
            end
         end

         ST_STOP: begin
            // Keep the phase energised for HOLD_CYC cycles, then report done.
            if (hold_r == HOLD_LAST) begin
               state_s = ST_IDLE;
               hold_s  = HOLD_ZERO;
               done_s  = 1'b1;
            end else begin
               hold_s = hold_r + HOLD_ONE;
            end
         end

         default: begin
            state_s = ST_IDLE;
            div_s   = DIV_ZERO;
            hold_s  = HOLD_ZERO;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs; reset discards any move in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r        <= DIV_ZERO;
         hold_r       <= HOLD_ZERO;
         remaining_r  <= CNT_ZERO;
         position_r   <= POS_ZERO;
         motor_dir_r  <= 1'b0;
         step_pulse_r <= 1'b0;
         done_r       <= 1'b0;
         limit_err_r  <= 1'b0;
         motor_hold_r <= 1'b1;
      end else begin
         div_r        <= div_s;
         hold_r       <= hold_s;
         remaining_r  <= remaining_s;
         position_r   <= position_s;
         motor_dir_r  <= motor_dir_s;
         step_pulse_r <= step_pulse_s;
         done_r       <= done_s;
         limit_err_r  <= limit_err_s;
         motor_hold_r <= (state_s == ST_IDLE);
      end
   end

   assign cmd_ready  = (state_r == ST_IDLE);
   assign busy       = (state_r == ST_RUN) | (state_r == ST_STOP);
   assign step_pulse = step_pulse_r;
   assign motor_dir  = motor_dir_r;
   assign motor_hold = motor_hold_r;
   assign done       = done_r;
   assign limit_err  = limit_err_r;
   assign position   = position_r;

   elevator_step_sequencer_chk #(
      .POS_W   (POS_W),
      .POS_MAX (POS_MAX)
   ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .step_pulse (step_pulse),
      .motor_hold (motor_hold),
      .done       (done),
      .limit_err  (limit_err),
      .position   (position)
   );

endmodule

// ----------------------------------------------------------------------------
// elevator_step_sequencer_chk
// Invariants of the sequencer's externally visible behaviour.
// ----------------------------------------------------------------------------

module elevator_step_sequencer_chk #(
   parameter int POS_W   = 16,
   parameter int POS_MAX = 4000
) (
   input logic             clk,
   input logic             reset,
   input logic             cmd_ready,
   input logic             busy,
   input logic             step_pulse,
   input logic             motor_hold,
   input logic             done,
   input logic             limit_err,
   input logic [POS_W-1:0] position
);

   localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

   // The motor is never stepped while the phase is held in its initial state.
   a_step_not_held: assert property (@(posedge clk) disable iff (reset)
      step_pulse |-> !motor_hold);

   // Car position stays inside the shaft.
   a_pos_in_range: assert property (@(posedge clk) disable iff (reset)
      position <= POS_TOP);

   // Ready and busy are exact complements.
   a_ready_busy: assert property (@(posedge clk) disable iff (reset)
      cmd_ready == !busy);

   // Completion is only ever reported from IDLE.
   a_done_idle: assert property (@(posedge clk) disable iff (reset)
      done |-> !busy);

   // A limit hit always lands in STOP.
   a_limit_busy: assert property (@(posedge clk) disable iff (reset)
      limit_err |-> busy);

endmodule
